// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain controller of the async FIFO with a 2-entry prefetch buffer.
// Define FIFO_RD_LEVEL_EN to add the rd_level occupancy output.
module fifo_read_ctrl #(
   parameter int unsigned n           = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         rclk,
   input  logic         rrst,
   input  logic [n-1:0] wptr_gray,
   output logic [n-1:0] rptr_gray,
   output logic [n-2:0] raddr,
   output logic         renable,
   input  logic [7:0]   mem_data,
   output logic [7:0]   rd_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic         empty
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [n-1:0] rd_level
`endif
);

   localparam int unsigned DW = 8;

   function automatic logic [n-1:0] gray2bin(input logic [n-1:0] g);
      logic [n-1:0] b;
      b = '0;
      for (int i = 0; i < n; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   function automatic logic [n-1:0] bin2gray(input logic [n-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [n-1:0]  sync_q [SYNC_STAGES];
   logic [n-1:0]  wsync_gray;
   logic [n-1:0]  wbin_s;
   logic [n-1:0]  rbin;
   logic [n-1:0]  rbin_inc_c;
   logic [n-1:0]  fill_c;
   logic          inflight;
   logic [1:0]    buf_count;
   logic          head;
   logic          tail_c;
   logic [DW-1:0] buf_q [2];
   logic          pop_c;
   logic          issue_c;
   logic [2:0]    occ_after_pop_c;

   // Write-pointer synchroniser into rclk
   always_ff @(posedge rclk) begin
      if (rrst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wsync_gray = sync_q[SYNC_STAGES-1];
   assign wbin_s     = gray2bin(wsync_gray);
   assign fill_c     = wbin_s - rbin;
   assign rbin_inc_c = rbin + n'(1);

   assign rd_valid        = (buf_count != 2'd0);
   assign rd_data         = buf_q[head];
   assign pop_c           = rd_valid & rd_ready;
   assign occ_after_pop_c = 3'(buf_count) + 3'(inflight) - 3'(pop_c);
   // Only fetch when the word in flight is guaranteed a buffer slot
   assign issue_c         = (fill_c != '0) && (occ_after_pop_c <= 3'd1);
   assign tail_c          = head ^ buf_count[0];

   assign renable = issue_c;
   assign raddr   = rbin[n-2:0];
   assign empty   = (fill_c == '0) && !inflight && (buf_count == 2'd0);

`ifdef FIFO_RD_LEVEL_EN
   assign rd_level = fill_c + n'(inflight) + n'(buf_count);
`endif

   // Read pointers, in-flight tracking and prefetch buffer
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin      <= '0;
         rptr_gray <= '0;
         inflight  <= 1'b0;
         head      <= 1'b0;
         buf_count <= 2'd0;
         buf_q[0]  <= '0;
         buf_q[1]  <= '0;
      end else begin
         if (issue_c) begin
            rbin      <= rbin_inc_c;
            rptr_gray <= bin2gray(rbin_inc_c);
         end
         inflight <= issue_c;
         if (inflight) begin
            buf_q[tail_c] <= mem_data;
         end
         if (pop_c) begin
            head <= ~head;
         end
         buf_count <= 2'(occ_after_pop_c);
      end
   end

endmodule
